// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller beside ID: operand forward selects, load-use and
// long-op scoreboard stalls. Define HAZARD_PERF_CNT_EN to build the stall perf counters.
module hazard_scoreboard #(
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_STAGES   = 3,
    parameter int MAX_LONG     = 4,
    parameter int SEL_W        = $clog2(NUM_STAGES + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          id_valid,
    input  logic                          id_hold,
    input  logic [5*NUM_RD_PORTS-1:0]     id_rs_addr,
    input  logic [NUM_RD_PORTS-1:0]       id_rs_used,
    input  logic [4:0]                    id_rd,
    input  logic                          id_reg_write,
    input  logic                          id_long_op,
    input  logic [5*NUM_STAGES-1:0]       stg_rd,
    input  logic [NUM_STAGES-1:0]         stg_reg_write,
    input  logic [NUM_STAGES-1:0]         stg_data_ok,
    input  logic                          lo_wb_valid,
    input  logic [4:0]                    lo_wb_rd,
    output logic [SEL_W*NUM_RD_PORTS-1:0] fwd_sel,
    output logic                          stall,
    output logic                          id_fire,
    output logic [31:0]                   busy_vec,
    output logic [4:0]                    long_cnt,
    output logic [31:0]                   perf_stall_lu,
    output logic [31:0]                   perf_stall_sb
);

    logic [31:0]             r_busy;
    logic [4:0]              r_long_cnt;
    logic [31:0]             w_busy_nxt;
    logic [NUM_RD_PORTS-1:0] w_port_lu;
    logic [NUM_RD_PORTS-1:0] w_port_sb;
    logic                    w_lu;
    logic                    w_sb;
    logic                    w_waw;
    logic                    w_full;
    logic                    w_stall;
    logic                    w_fire;
    logic                    w_set;
    logic                    w_inc;
    logic                    w_dec;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        logic [4:0]       w_rs;
        logic             w_active;
        logic             w_hit;
        logic             w_ok;
        logic [SEL_W-1:0] w_sel;

        assign w_rs     = id_rs_addr[5*p +: 5];
        assign w_active = id_rs_used[p] & (w_rs != 5'd0);

        // Oldest-to-youngest scan: a younger match overwrites any older one.
        always_comb begin
            w_hit = 1'b0;
            w_ok  = 1'b0;
            w_sel = '0;
            for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                if (stg_reg_write[NUM_STAGES-1-i] &&
                    stg_rd[5*(NUM_STAGES-1-i) +: 5] == w_rs) begin
                    w_hit = 1'b1;
                    w_ok  = stg_data_ok[NUM_STAGES-1-i];
                    w_sel = SEL_W'(NUM_STAGES - i);
                end
            end
        end

        assign w_port_lu[p] = w_active & w_hit & ~w_ok;
        assign w_port_sb[p] = w_active & ~w_hit & r_busy[w_rs];
        assign fwd_sel[SEL_W*p +: SEL_W] = (w_active & w_hit & w_ok) ? w_sel : '0;
    end

    assign w_lu    = |w_port_lu;
    assign w_waw   = id_reg_write & r_busy[id_rd];
    assign w_full  = id_long_op & (r_long_cnt == 5'(MAX_LONG));
    assign w_sb    = (|w_port_sb) | w_waw | w_full;
    assign w_stall = id_valid & (w_lu | w_sb);
    assign w_fire  = id_valid & ~w_stall & ~id_hold;

    assign w_set = w_fire & id_long_op & id_reg_write & (id_rd != 5'd0);
    assign w_inc = w_fire & id_long_op;
    assign w_dec = lo_wb_valid;

    // Clear applied first so a same-cycle set of the same register wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (lo_wb_valid) w_busy_nxt[lo_wb_rd] = 1'b0;
        if (w_set)       w_busy_nxt[id_rd]    = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_long_cnt <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_inc && !w_dec)
                r_long_cnt <= r_long_cnt + 5'd1;
            else if (!w_inc && w_dec && r_long_cnt != 5'd0)
                r_long_cnt <= r_long_cnt - 5'd1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_perf_lu;
    logic [31:0] r_perf_sb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_lu <= '0;
            r_perf_sb <= '0;
        end else begin
            if (w_stall && w_lu && r_perf_lu != '1)
                r_perf_lu <= r_perf_lu + 32'd1;
            if (w_stall && !w_lu && r_perf_sb != '1)
                r_perf_sb <= r_perf_sb + 32'd1;
        end
    end

    assign perf_stall_lu = r_perf_lu;
    assign perf_stall_sb = r_perf_sb;
`else
    assign perf_stall_lu = '0;
    assign perf_stall_sb = '0;
`endif

    assign stall    = w_stall;
    assign id_fire  = w_fire;
    assign busy_vec = r_busy;
    assign long_cnt = r_long_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: per-cycle comparison against a
// rule-level model plus hand-computed literal expectations.
module tb_hazard_scoreboard;

    localparam int NP = 2;
    localparam int NS = 3;
    localparam int ML = 4;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            id_valid, id_hold, id_reg_write, id_long_op, lo_wb_valid;
    logic [5*NP-1:0] id_rs_addr;
    logic [NP-1:0]   id_rs_used;
    logic [4:0]      id_rd, lo_wb_rd;
    logic [5*NS-1:0] stg_rd;
    logic [NS-1:0]   stg_reg_write, stg_data_ok;
    logic [SW*NP-1:0] fwd_sel;
    logic            stall, id_fire;
    logic [31:0]     busy_vec, perf_stall_lu, perf_stall_sb;
    logic [4:0]      long_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_scoreboard #(
        .NUM_RD_PORTS(NP),
        .NUM_STAGES  (NS),
        .MAX_LONG    (ML)
    ) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_hold(id_hold),
        .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_long_op(id_long_op),
        .stg_rd(stg_rd), .stg_reg_write(stg_reg_write), .stg_data_ok(stg_data_ok),
        .lo_wb_valid(lo_wb_valid), .lo_wb_rd(lo_wb_rd),
        .fwd_sel(fwd_sel), .stall(stall), .id_fire(id_fire),
        .busy_vec(busy_vec), .long_cnt(long_cnt),
        .perf_stall_lu(perf_stall_lu), .perf_stall_sb(perf_stall_sb)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state
    bit [31:0] busy_m;
    int        cnt_m;
    bit [31:0] lu_m, sb_m;

    // Expected combinational outputs from the rules, given inputs and model state
    task automatic model_eval(output logic [SW*NP-1:0] sel, output bit st, output bit fi,
                              output bit lu_st, output bit sb_st);
        bit lu, sb;
        int found;
        logic [4:0] rs;
        sel = '0; lu = 0; sb = 0;
        for (int p = 0; p < NP; p++) begin
            rs = id_rs_addr[5*p +: 5];
            if (!id_rs_used[p] || rs == 5'd0) continue;
            found = -1;
            for (int k = 0; k < NS; k++) begin
                if (stg_reg_write[k] && stg_rd[5*k +: 5] == rs) begin
                    found = k;
                    break;
                end
            end
            if (found < 0) begin
                if (busy_m[rs]) sb = 1;
            end else if (stg_data_ok[found]) begin
                sel[SW*p +: SW] = SW'(found + 1);
            end else begin
                lu = 1;
            end
        end
        if (id_reg_write && busy_m[id_rd]) sb = 1;
        if (id_long_op && cnt_m == ML) sb = 1;
        st    = id_valid && (lu || sb);
        fi    = id_valid && !st && !id_hold;
        lu_st = id_valid && lu;
        sb_st = id_valid && sb && !lu;
    endtask

    logic [SW*NP-1:0] m_sel;
    bit               m_st, m_fi, m_lu, m_sb;
    bit [31:0]        m_busy_n;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_m <= '0;
            cnt_m  <= 0;
            lu_m   <= '0;
            sb_m   <= '0;
        end else begin
            model_eval(m_sel, m_st, m_fi, m_lu, m_sb);
            m_busy_n = busy_m;
            if (lo_wb_valid) m_busy_n[lo_wb_rd] = 1'b0;
            if (m_fi && id_long_op && id_reg_write && id_rd != 5'd0) m_busy_n[id_rd] = 1'b1;
            busy_m <= m_busy_n;
            if (m_fi && id_long_op && !lo_wb_valid) cnt_m <= cnt_m + 1;
            else if (!(m_fi && id_long_op) && lo_wb_valid && cnt_m > 0) cnt_m <= cnt_m - 1;
`ifdef HAZARD_PERF_CNT_EN
            if (m_lu && lu_m != 32'hFFFF_FFFF) lu_m <= lu_m + 1;
            if (m_sb && sb_m != 32'hFFFF_FFFF) sb_m <= sb_m + 1;
`endif
        end
    end

    logic [SW*NP-1:0] c_sel;
    bit               c_st, c_fi, c_lu, c_sb;

    always @(negedge clk) begin
        model_eval(c_sel, c_st, c_fi, c_lu, c_sb);
        check("m_fwd_sel",  32'(fwd_sel),  32'(c_sel));
        check("m_stall",    32'(stall),    32'(c_st));
        check("m_id_fire",  32'(id_fire),  32'(c_fi));
        check("m_busy_vec", busy_vec,      busy_m);
        check("m_long_cnt", 32'(long_cnt), 32'(cnt_m));
        check("m_perf_lu",  perf_stall_lu, lu_m);
        check("m_perf_sb",  perf_stall_sb, sb_m);
    end

    task automatic idle();
        id_valid = 0; id_hold = 0; id_reg_write = 0; id_long_op = 0; lo_wb_valid = 0;
        id_rs_addr = '0; id_rs_used = '0; id_rd = '0; lo_wb_rd = '0;
        stg_rd = '0; stg_reg_write = '0; stg_data_ok = '0;
    endtask

    task automatic set_stage(input int k, input logic [4:0] rd, input logic rw, input logic ok);
        stg_rd[5*k +: 5] = rd;
        stg_reg_write[k] = rw;
        stg_data_ok[k]   = ok;
    endtask

    task automatic set_port(input int p, input logic [4:0] rs, input logic used);
        id_rs_addr[5*p +: 5] = rs;
        id_rs_used[p]        = used;
    endtask

    task automatic long_issue(input logic [4:0] rd);
        idle();
        id_valid = 1; id_long_op = 1; id_reg_write = 1; id_rd = rd;
    endtask

    task automatic settle(); @(negedge clk); #1; endtask
    task automatic adv();    @(posedge clk); #1; endtask

    initial begin
        idle();
        rst_n = 0;
        #12;
        check("rst_busy", busy_vec, 32'h0);
        check("rst_cnt", 32'(long_cnt), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_fire", 32'(id_fire), 32'd0);
        check("rst_fwd", 32'(fwd_sel), 32'd0);
        check("rst_perf_lu", perf_stall_lu, 32'd0);
        rst_n = 1;
        adv();

        // Youngest match wins
        idle(); id_valid = 1;
        set_stage(0, 5, 1, 1); set_stage(1, 5, 1, 1); set_port(0, 5, 1);
        settle();
        check("t1_fwd0", 32'(fwd_sel[1:0]), 32'd1);
        check("t1_stall", 32'(stall), 32'd0);
        check("t1_fire", 32'(id_fire), 32'd1);
        adv();

        // Load-use for three cycles, then forwarded from MEM
        idle(); id_valid = 1; set_stage(0, 7, 1, 0); set_port(1, 7, 1);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t2_lu_stall", 32'(stall), 32'd1);
            check("t2_lu_fire", 32'(id_fire), 32'd0);
            check("t2_lu_fwd1", 32'(fwd_sel[3:2]), 32'd0);
            adv();
        end
        idle(); id_valid = 1; set_stage(1, 7, 1, 1); set_port(1, 7, 1);
        settle();
        check("t2_fwd1", 32'(fwd_sel[3:2]), 32'd2);
        check("t2_stall", 32'(stall), 32'd0);
        adv();

        // Long op to x9, dependent reader stalls until writeback
        long_issue(9);
        settle(); check("t3_issue_fire", 32'(id_fire), 32'd1);
        adv();
        idle(); id_valid = 1; set_port(0, 9, 1);
        settle();
        check("t3_busy", busy_vec, 32'h0000_0200);
        check("t3_cnt", 32'(long_cnt), 32'd1);
        check("t3_stall", 32'(stall), 32'd1);
        adv();
        lo_wb_valid = 1; lo_wb_rd = 9;
        settle(); check("t3_wb_nobypass", 32'(stall), 32'd1);
        adv();
        lo_wb_valid = 0;
        settle();
        check("t3_busy_clr", busy_vec, 32'h0);
        check("t3_cnt_clr", 32'(long_cnt), 32'd0);
        check("t3_fire", 32'(id_fire), 32'd1);
`ifdef HAZARD_PERF_CNT_EN
        check("t3_perf_lu", perf_stall_lu, 32'd3);
        check("t3_perf_sb", perf_stall_sb, 32'd2);
`else
        check("t3_perf_lu", perf_stall_lu, 32'd0);
        check("t3_perf_sb", perf_stall_sb, 32'd0);
`endif
        adv();

        // Fill to MAX_LONG, fifth stalls
        for (int r = 1; r <= 4; r++) begin
            long_issue(5'(r));
            settle(); check("t4_fill_fire", 32'(id_fire), 32'd1);
            adv();
        end
        long_issue(10);
        settle();
        check("t4_busy", busy_vec, 32'h0000_001E);
        check("t4_cnt", 32'(long_cnt), 32'd4);
        check("t4_full_stall", 32'(stall), 32'd1);
        check("t4_full_fire", 32'(id_fire), 32'd0);
        adv();
        idle(); lo_wb_valid = 1; lo_wb_rd = 2;
        adv();
        // Writeback to x2 (now idle) together with a new long op to x2: set wins
        long_issue(2); lo_wb_valid = 1; lo_wb_rd = 2;
        settle();
        check("t4_busy_pre", busy_vec, 32'h0000_001A);
        check("t4_cnt_pre", 32'(long_cnt), 32'd3);
        check("t4_set_fire", 32'(id_fire), 32'd1);
        adv();
        idle();
        settle();
        check("t4_busy_set", busy_vec, 32'h0000_001E);
        check("t4_cnt_same", 32'(long_cnt), 32'd3);
        adv();
        long_issue(11); id_hold = 1;
        settle();
        check("t4_hold_stall", 32'(stall), 32'd0);
        check("t4_hold_fire", 32'(id_fire), 32'd0);
        adv();

        // x0 never forwards nor stalls
        idle(); id_valid = 1;
        for (int k = 0; k < NS; k++) set_stage(k, 0, 1, 0);
        set_port(0, 0, 1); set_port(1, 0, 1);
        settle();
        check("t5_fwd", 32'(fwd_sel), 32'd0);
        check("t5_stall", 32'(stall), 32'd0);
        check("t5_fire", 32'(id_fire), 32'd1);
        adv();

        // Asynchronous reset mid-operation
        idle(); rst_n = 0; #2; rst_n = 1;
        adv();
        long_issue(9);
        adv();
        idle();
        settle();
        check("t6_busy", busy_vec, 32'h0000_0200);
        check("t6_cnt", 32'(long_cnt), 32'd1);
        #1 rst_n = 0;
        #1;
        check("t6_async_busy", busy_vec, 32'h0);
        check("t6_async_cnt", 32'(long_cnt), 32'd0);
        check("t6_async_perf", perf_stall_lu | perf_stall_sb, 32'd0);
        rst_n = 1;
        adv();
        lo_wb_valid = 1; lo_wb_rd = 9;
        adv();
        idle();
        settle();
        check("t6_no_underflow", 32'(long_cnt), 32'd0);
        check("t6_busy_stays", busy_vec, 32'h0);
        adv();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the RV32I pipeline.
- Generalises per-stage forwarding to N read ports and S forwarding stages. Detects load-use hazards from per-stage data-ready flags.
- Adds a register scoreboard for long-latency out-of-band results (div/mul/uncached load) that tracks outstanding writers and stalls issue.
- Sits beside ID; drives operand mux selects and the ID stall.

Parameters:
- NUM_RD_PORTS, 2, source operand ports checked per cycle
- NUM_STAGES, 3, forwarding stages; index 0 = youngest (EX), NUM_STAGES-1 = oldest (WB)
- MAX_LONG, 4, max outstanding long-latency ops; range 1..31
- SEL_W, $clog2(NUM_STAGES+1), forward select width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- id_valid  in  1  instruction present in ID
- id_hold  in  1  external stall (e.g. fetch miss); blocks issue
- id_rs_addr  in  5*NUM_RD_PORTS  packed source registers; port p at [5p+4:5p]
- id_rs_used  in  NUM_RD_PORTS  source actually read
- id_rd  in  5  destination register
- id_reg_write  in  1  instruction writes id_rd
- id_long_op  in  1  result returns via the long-op writeback port
- stg_rd  in  5*NUM_STAGES  packed stage destination registers
- stg_reg_write  in  NUM_STAGES  stage will write its rd
- stg_data_ok  in  NUM_STAGES  stage result already computed (0 for a load in EX)
- lo_wb_valid  in  1  long-op result written this cycle
- lo_wb_rd  in  5  long-op destination
- fwd_sel  out  SEL_W*NUM_RD_PORTS  per port: 0 = regfile, k = stage k-1
- stall  out  1  ID must hold
- id_fire  out  1  instruction issues this cycle
- busy_vec  out  32  scoreboard bits (bit 0 always 0)
- long_cnt  out  5  outstanding long ops
- perf_stall_lu  out  32  load-use stall cycles
- perf_stall_sb  out  32  scoreboard stall cycles

Behaviour:
- Clock and reset:
  - Single clock, posedge.
  - rst_n is asynchronous, active-low. Asserting it clears busy_vec, long_cnt and both perf counters to 0.
  - fwd_sel, stall and id_fire are combinational from inputs and state. With all inputs 0 after reset they read 0.
- Forwarding, per used port p with rs != 0:
  - Scan stages 0..NUM_STAGES-1. The first stage with stg_reg_write=1 and stg_rd==rs is the match; the youngest match wins and older stages are ignored.
  - If the match has stg_data_ok=1: fwd_sel=k+1.
  - If the match has stg_data_ok=0: load-use hazard; fwd_sel=0.
  - No match: fwd_sel=0.
  - Unused ports and rs==x0 always give 0.
- Scoreboard stall, any of:
  - a used port's rs has busy=1 and no stage match;
  - id_reg_write=1 and busy[id_rd]=1 (WAW);
  - id_long_op=1 and long_cnt==MAX_LONG.
- Stall and issue:
  - stall = id_valid & (load-use | scoreboard).
  - id_fire = id_valid & ~stall & ~id_hold.
- Scoreboard update (registered):
  - Set: id_fire & id_long_op & id_reg_write & id_rd!=0 sets busy[id_rd].
  - Clear: lo_wb_valid clears busy[lo_wb_rd].
  - Same register set and cleared in one cycle: set wins.
  - lo_wb_valid for a non-busy register: no state change except the long_cnt rule below.
- long_cnt:
  - +1 on id_fire & id_long_op; -1 on lo_wb_valid.
  - Both in one cycle: unchanged.
  - Saturates at 0 and never underflows. Cannot exceed MAX_LONG because of the stall rule.
- Latency: a long-op result written at cycle t is visible to ID at t+1 (busy cleared). A same-cycle bypass is not required.
- Reset mid-operation: in-flight long ops are forgotten. A later lo_wb_valid is accepted without error.

Optional Feature:
- HAZARD_PERF_CNT_EN:
  - Defined: perf_stall_lu increments each cycle stall is caused by load-use. perf_stall_sb increments each cycle stall is caused by the scoreboard only, i.e. not load-use. Both are 32-bit and saturate at 0xFFFFFFFF.
  - Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- EX writes x5 with data_ok=1, MEM also writes x5, port0 rs=x5 → fwd_sel[0]=1 (youngest wins), stall=0.
- EX is a load to x7 (data_ok=0), port1 rs=x7, id_valid=1 → stall=1, id_fire=0, fwd_sel[1]=0. Next cycle the load is in MEM with data_ok=1 → fwd_sel[1]=2, stall=0.
- Issue a long op to x9 → busy_vec[9]=1, long_cnt=1. Next instruction reads x9 → stall until lo_wb_valid with rd=9; busy_vec[9] clears the following cycle and the instruction issues.
- Issue MAX_LONG=4 long ops to x1..x4, then a fifth → stall. Same cycle lo_wb_valid for x2 and id_fire of a new long op to x2 → busy[2]=1, long_cnt unchanged.
- rs=x0 with every stage writing x0 → fwd_sel=0, stall=0. rst_n asserted with busy=0x0000_0200 → all state 0 immediately, without waiting for a clock edge.
- With HAZARD_PERF_CNT_EN defined: 3 load-use and 2 scoreboard stall cycles → perf_stall_lu=3, perf_stall_sb=2. Undefined → both remain 0.
